multi_cycle_control: RTL and testbench

// - Multi-cycle successor to the single-cycle decoder. It is a Moore/Mealy FSM that

---
 rtl/multi_cycle_control.sv | 201 ++++++++++++++++++++
 tb/tb_multi_cycle_control.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/multi_cycle_control.sv
// rtl/multi_cycle_control.sv - multi-cycle MIPS control FSM with shared memory port handshake
module multi_cycle_control #(
    parameter int MEM_TIMEOUT = 16,
    parameter bit HAS_SHIFT   = 1'b1,
    parameter int ALU_CTRL_W  = 4
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic [5:0]            op_i,
    input  logic [5:0]            funct_i,
    input  logic                  zero_i,
    input  logic                  mem_ready_i,
    output logic                  mem_req_o,
    output logic                  mem_we_o,
    output logic                  iord_o,
    output logic                  ir_write_o,
    output logic                  pc_en_o,
    output logic [1:0]            pc_src_o,
    output logic [1:0]            alu_src_a_o,
    output logic [2:0]            alu_src_b_o,
    output logic [ALU_CTRL_W-1:0] alu_control_o,
    output logic [1:0]            reg_dst_o,
    output logic [1:0]            mem_to_reg_o,
    output logic                  reg_write_o,
    output logic                  instr_done_o,
    output logic                  error_o
);
    localparam logic [5:0] OP_R = 6'h00, OP_J = 6'h02, OP_JAL = 6'h03, OP_BEQ = 6'h04,
                           OP_BNE = 6'h05, OP_ADDI = 6'h08, OP_SLTI = 6'h0A,
                           OP_ANDI = 6'h0C, OP_ORI = 6'h0D, OP_LW = 6'h23, OP_SW = 6'h2B;
    localparam logic [5:0] FN_JR = 6'b001000;
    localparam int CW = (MEM_TIMEOUT > 0) ? $clog2(MEM_TIMEOUT + 1) : 1;
    localparam logic [CW-1:0] TO_LAST = CW'((MEM_TIMEOUT > 0) ? MEM_TIMEOUT - 1 : 0);

    typedef enum logic [3:0] {
        S_FETCH, S_DECODE, S_MEM_ADR, S_MEM_RD, S_MEM_WR, S_MEM_WB, S_EXEC_R,
        S_ALU_WB, S_EXEC_I, S_IMM_WB, S_BRANCH, S_JUMP, S_ERROR
    } state_t;

    state_t        state, nxt;
    logic [CW-1:0] wait_cnt;
    logic          req_raw;
    logic          r_ok, r_shift;
    logic [3:0]    r_alu, alu_c;

    // R-type funct decode: ALU code, shift flag and legality
    always_comb begin
        r_ok    = 1'b1;
        r_shift = 1'b0;
        r_alu   = 4'd0;
        case (funct_i)
            6'b100000: r_alu = 4'd2;
            6'b100010: r_alu = 4'd6;
            6'b100100: r_alu = 4'd0;
            6'b100101: r_alu = 4'd1;
            6'b101010: r_alu = 4'd7;
            6'b000000: begin r_alu = 4'd3; r_shift = 1'b1; r_ok = HAS_SHIFT; end
            6'b000010: begin r_alu = 4'd8; r_shift = 1'b1; r_ok = HAS_SHIFT; end
            6'b000011: begin r_alu = 4'd9; r_shift = 1'b1; r_ok = HAS_SHIFT; end
            default:   r_ok = 1'b0;
        endcase
    end

    assign req_raw = (state == S_FETCH) || (state == S_MEM_RD) || (state == S_MEM_WR);

    // Next-state selection, with the memory wait timeout overriding everything
    always_comb begin
        nxt = state;
        case (state)
            S_FETCH:   if (mem_ready_i) nxt = S_DECODE;
            S_DECODE: begin
                case (op_i)
                    OP_LW, OP_SW:                      nxt = S_MEM_ADR;
                    OP_R:                              nxt = (funct_i == FN_JR) ? S_JUMP : S_EXEC_R;
                    OP_ADDI, OP_SLTI, OP_ANDI, OP_ORI: nxt = S_EXEC_I;
                    OP_BEQ, OP_BNE:                    nxt = S_BRANCH;
                    OP_J, OP_JAL:                      nxt = S_JUMP;
                    default:                           nxt = S_ERROR;
                endcase
            end
            S_MEM_ADR: nxt = (op_i == OP_LW) ? S_MEM_RD : S_MEM_WR;
            S_MEM_RD:  if (mem_ready_i) nxt = S_MEM_WB;
            S_MEM_WR:  if (mem_ready_i) nxt = S_FETCH;
            S_EXEC_R:  nxt = r_ok ? S_ALU_WB : S_ERROR;
            S_EXEC_I:  nxt = S_IMM_WB;
            S_ERROR:   nxt = S_ERROR;
            default:   nxt = S_FETCH;
        endcase
        if (MEM_TIMEOUT > 0 && req_raw && !mem_ready_i && wait_cnt == TO_LAST)
            nxt = S_ERROR;
    end

    // State register and stall counter; the counter restarts on any progress
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state    <= S_FETCH;
            wait_cnt <= '0;
        end else begin
            state <= nxt;
            if (nxt != state || mem_ready_i || !req_raw)
                wait_cnt <= '0;
            else
                wait_cnt <= wait_cnt + CW'(1);
        end
    end

    // Output decode; holding reset kills the memory request and any write-back at once
    always_comb begin
        mem_req_o    = 1'b0;
        mem_we_o     = 1'b0;
        iord_o       = 1'b0;
        ir_write_o   = 1'b0;
        pc_en_o      = 1'b0;
        pc_src_o     = 2'd0;
        alu_src_a_o  = 2'd0;
        alu_src_b_o  = 3'd0;
        alu_c        = 4'd0;
        reg_dst_o    = 2'd0;
        mem_to_reg_o = 2'd0;
        reg_write_o  = 1'b0;
        instr_done_o = 1'b0;
        error_o      = 1'b0;
        if (rst_ni) begin
            case (state)
                S_FETCH: begin
                    mem_req_o   = 1'b1;
                    alu_src_b_o = 3'd1;
                    alu_c       = 4'd2;
                    ir_write_o  = mem_ready_i;
                    pc_en_o     = mem_ready_i;
                end
                S_DECODE: begin
                    alu_src_b_o = 3'd3;
                    alu_c       = 4'd2;
                end
                S_MEM_ADR: begin
                    alu_src_a_o = 2'd1;
                    alu_src_b_o = 3'd2;
                    alu_c       = 4'd2;
                end
                S_MEM_RD: begin
                    mem_req_o = 1'b1;
                    iord_o    = 1'b1;
                end
                S_MEM_WR: begin
                    mem_req_o    = 1'b1;
                    mem_we_o     = 1'b1;
                    iord_o       = 1'b1;
                    instr_done_o = mem_ready_i;
                end
                S_MEM_WB: begin
                    reg_write_o  = 1'b1;
                    mem_to_reg_o = 2'd1;
                    instr_done_o = 1'b1;
                end
                S_EXEC_R: begin
                    alu_src_a_o = r_shift ? 2'd2 : 2'd1;
                    alu_c       = r_alu;
                end
                S_ALU_WB: begin
                    reg_write_o  = 1'b1;
                    reg_dst_o    = 2'd1;
                    instr_done_o = 1'b1;
                end
                S_EXEC_I: begin
                    alu_src_a_o = 2'd1;
                    case (op_i)
                        OP_ADDI: begin alu_src_b_o = 3'd2; alu_c = 4'd2; end
                        OP_SLTI: begin alu_src_b_o = 3'd2; alu_c = 4'd7; end
                        OP_ANDI: begin alu_src_b_o = 3'd4; alu_c = 4'd0; end
                        default: begin alu_src_b_o = 3'd4; alu_c = 4'd1; end
                    endcase
                end
                S_IMM_WB: begin
                    reg_write_o  = 1'b1;
                    instr_done_o = 1'b1;
                end
                S_BRANCH: begin
                    alu_src_a_o  = 2'd1;
                    alu_c        = 4'd6;
                    pc_src_o     = 2'd1;
                    instr_done_o = 1'b1;
                    pc_en_o      = ((op_i == OP_BEQ) && zero_i) || ((op_i == OP_BNE) && !zero_i);
                end
                S_JUMP: begin
                    pc_en_o      = 1'b1;
                    instr_done_o = 1'b1;
                    pc_src_o     = (op_i == OP_R) ? 2'd3 : 2'd2;
                    if (op_i == OP_JAL) begin
                        reg_write_o  = 1'b1;
                        reg_dst_o    = 2'd2;
                        mem_to_reg_o = 2'd2;
                    end
                end
                default: error_o = 1'b1;
            endcase
        end
    end

    assign alu_control_o = ALU_CTRL_W'(alu_c);
endmodule

// File: tb/tb_multi_cycle_control.sv
// tb/tb_multi_cycle_control.sv - directed self-checking bench for multi_cycle_control
module tb_multi_cycle_control;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [5:0] op = 6'd0, funct = 6'd0;
    logic       zero = 1'b0, ready = 1'b0;

    logic       mem_req, mem_we, iord, ir_write, pc_en, reg_write, done, err;
    logic [1:0] pc_src, src_a, reg_dst, m2r;
    logic [2:0] src_b;
    logic [3:0] alu;
    logic       mem_req1, mem_we1, iord1, ir_write1, pc_en1, reg_write1, done1, err1;
    logic [1:0] pc_src1, src_a1, reg_dst1, m2r1;
    logic [2:0] src_b1;
    logic [3:0] alu1;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    multi_cycle_control #(.MEM_TIMEOUT(16), .HAS_SHIFT(1'b1), .ALU_CTRL_W(4)) dut (
        .clk_i(clk), .rst_ni(rst_n), .op_i(op), .funct_i(funct), .zero_i(zero),
        .mem_ready_i(ready), .mem_req_o(mem_req), .mem_we_o(mem_we), .iord_o(iord),
        .ir_write_o(ir_write), .pc_en_o(pc_en), .pc_src_o(pc_src), .alu_src_a_o(src_a),
        .alu_src_b_o(src_b), .alu_control_o(alu), .reg_dst_o(reg_dst), .mem_to_reg_o(m2r),
        .reg_write_o(reg_write), .instr_done_o(done), .error_o(err));

    multi_cycle_control #(.MEM_TIMEOUT(16), .HAS_SHIFT(1'b0), .ALU_CTRL_W(4)) dut_ns (
        .clk_i(clk), .rst_ni(rst_n), .op_i(op), .funct_i(funct), .zero_i(zero),
        .mem_ready_i(ready), .mem_req_o(mem_req1), .mem_we_o(mem_we1), .iord_o(iord1),
        .ir_write_o(ir_write1), .pc_en_o(pc_en1), .pc_src_o(pc_src1), .alu_src_a_o(src_a1),
        .alu_src_b_o(src_b1), .alu_control_o(alu1), .reg_dst_o(reg_dst1), .mem_to_reg_o(m2r1),
        .reg_write_o(reg_write1), .instr_done_o(done1), .error_o(err1));

    wire [22:0] outs  = {mem_req, mem_we, iord, ir_write, pc_en, pc_src, src_a, src_b, alu,
                         reg_dst, m2r, reg_write, done, err};
    wire [22:0] outs1 = {mem_req1, mem_we1, iord1, ir_write1, pc_en1, pc_src1, src_a1, src_b1, alu1,
                         reg_dst1, m2r1, reg_write1, done1, err1};

    function automatic logic [22:0] mk(input logic rq, we, ia, irw, pce, input logic [1:0] ps, sa,
                                       input logic [2:0] sb, input logic [3:0] al,
                                       input logic [1:0] rd, mr, input logic rw, dn, er);
        return {rq, we, ia, irw, pce, ps, sa, sb, al, rd, mr, rw, dn, er};
    endfunction

    task automatic chk(input string tag, input logic [22:0] obs, input logic [22:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        #1 rst_n = 1'b0;
        #1;
        chk("in_reset", outs, '0);
        tick();
        rst_n = 1'b1;
        #1;
    endtask

    // Run FETCH and DECODE with ready high, leaving the FSM in the execute-step state
    task automatic fetch_decode(input logic [5:0] o, input logic [5:0] f);
        op = o; funct = f; ready = 1'b1;
        #1;
        chk("fetch", outs, mk(1,0,0,1,1,0,0,1,2,0,0,0,0,0));
        tick();
        chk("decode", outs, mk(0,0,0,0,0,0,0,3,2,0,0,0,0,0));
        tick();
    endtask

    task automatic branch(input logic [5:0] o, input logic z, input logic exp_en);
        zero = z;
        fetch_decode(o, 6'd0);
        chk("branch", outs, mk(0,0,0,0,exp_en,1,1,0,6,0,0,0,1,0));
        tick();
    endtask

    initial begin
        ready = 1'b0;
        do_reset();
        chk("reset_state", outs, mk(1,0,0,0,0,0,0,1,2,0,0,0,0,0));

        // ADD: F, D, EX, WB
        fetch_decode(6'h00, 6'b100000);
        chk("add_exec", outs, mk(0,0,0,0,0,0,1,0,2,0,0,0,0,0));
        tick();
        chk("add_wb", outs, mk(0,0,0,0,0,0,0,0,0,1,0,1,1,0));
        tick();

        // LW with three wait cycles in MEM_RD
        fetch_decode(6'h23, 6'd0);
        chk("lw_adr", outs, mk(0,0,0,0,0,0,1,2,2,0,0,0,0,0));
        ready = 1'b0;
        tick();
        for (int i = 0; i < 3; i++) begin
            chk("lw_rd_wait", outs, mk(1,0,1,0,0,0,0,0,0,0,0,0,0,0));
            tick();
        end
        ready = 1'b1;
        #1;
        chk("lw_rd_done", outs, mk(1,0,1,0,0,0,0,0,0,0,0,0,0,0));
        tick();
        chk("lw_wb", outs, mk(0,0,0,0,0,0,0,0,0,0,1,1,1,0));
        tick();

        // SW
        fetch_decode(6'h2B, 6'd0);
        tick();
        chk("sw_wr", outs, mk(1,1,1,0,0,0,0,0,0,0,0,0,1,0));
        tick();

        branch(6'h04, 1'b1, 1'b1);
        branch(6'h04, 1'b0, 1'b0);
        branch(6'h05, 1'b0, 1'b1);
        branch(6'h05, 1'b1, 1'b0);

        fetch_decode(6'h03, 6'd0);
        chk("jal", outs, mk(0,0,0,0,1,2,0,0,0,2,2,1,1,0));
        tick();
        fetch_decode(6'h02, 6'd0);
        chk("j", outs, mk(0,0,0,0,1,2,0,0,0,0,0,0,1,0));
        tick();
        fetch_decode(6'h00, 6'b001000);
        chk("jr", outs, mk(0,0,0,0,1,3,0,0,0,0,0,0,1,0));
        tick();

        fetch_decode(6'h00, 6'b000011);
        chk("sra_exec", outs, mk(0,0,0,0,0,0,2,0,9,0,0,0,0,0));
        tick();
        chk("sra_wb", outs, mk(0,0,0,0,0,0,0,0,0,1,0,1,1,0));
        tick();

        fetch_decode(6'h08, 6'd0);
        chk("addi_exec", outs, mk(0,0,0,0,0,0,1,2,2,0,0,0,0,0));
        tick();
        chk("addi_wb", outs, mk(0,0,0,0,0,0,0,0,0,0,0,1,1,0));
        tick();
        fetch_decode(6'h0D, 6'd0);
        chk("ori_exec", outs, mk(0,0,0,0,0,0,1,4,1,0,0,0,0,0));
        tick();
        tick();

        // SLL: legal with shifts, illegal without
        do_reset();
        fetch_decode(6'h00, 6'b000000);
        chk("sll_exec", outs, mk(0,0,0,0,0,0,2,0,3,0,0,0,0,0));
        tick();
        chk("sll_noshift_err", outs1, mk(0,0,0,0,0,0,0,0,0,0,0,0,0,1));

        // Illegal opcode is sticky
        do_reset();
        fetch_decode(6'h3F, 6'd0);
        chk("illegal_err", outs, mk(0,0,0,0,0,0,0,0,0,0,0,0,0,1));
        tick();
        tick();
        chk("illegal_sticky", outs, mk(0,0,0,0,0,0,0,0,0,0,0,0,0,1));

        // FETCH timeout after 16 stalled cycles
        do_reset();
        ready = 1'b0;
        for (int i = 0; i < 15; i++) tick();
        chk("timeout_pre", outs, mk(1,0,0,0,0,0,0,1,2,0,0,0,0,0));
        tick();
        chk("timeout_err", outs, mk(0,0,0,0,0,0,0,0,0,0,0,0,0,1));
        do_reset();
        chk("timeout_recover", outs, mk(1,0,0,0,0,0,0,1,2,0,0,0,0,0));

        // Reset in the middle of a stalled read
        fetch_decode(6'h23, 6'd0);
        ready = 1'b0;
        tick();
        chk("mid_rd", outs, mk(1,0,1,0,0,0,0,0,0,0,0,0,0,0));
        #2 rst_n = 1'b0;
        #1;
        chk("mid_rst_drop", outs, '0);
        tick();
        rst_n = 1'b1;
        #1;
        chk("mid_rst_fetch", outs, mk(1,0,0,0,0,0,0,1,2,0,0,0,0,0));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
